// File: rtl/readout_seq_pkg.sv
// Shared types and default timing constants for the chip readout sequencer.
package readout_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RESET    = 3'd1,
      ST_TRIGGER  = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_READ     = 3'd4,
      ST_DONE     = 3'd5
   } state_e;

   localparam int DEF_RST_CYCLES     = 16;
   localparam int DEF_TRIG_CYCLES    = 4;
   localparam int DEF_TIMEOUT_CYCLES = 4096;
   localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/readout_sequencer.sv
// Chip readout sequencer: reset pulse, trigger pulse, wait for chip acknowledge,
// then gate read_clk for a latched number of cycles. All outputs are registered.
module readout_sequencer
   import readout_seq_pkg::*;
#(
   parameter int RST_CYCLES     = DEF_RST_CYCLES,
   parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] read_len,
   input  logic             trig_from_chip,
   output logic             chip_rst,
   output logic             trig_to_chip,
   output logic             read_clk_en,
   output logic             busy,
   output logic             done,
   output logic             timeout
);

   // The shared counter is loaded with N-1 on entry so a state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRIG_LOAD    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             ack_prev_q, ack_prev_d;
   logic             chip_rst_q, chip_rst_d;
   logic             trig_q, trig_d;
   logic             read_clk_en_q, read_clk_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;

   logic             ack_sync;
   logic             ack_rise;
   logic             cnt_zero;

   bit_sync_2ff u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (trig_from_chip),
      .q   (ack_sync)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      ack_prev_d = ack_sync;
      timeout_d  = 1'b0;
      ack_rise   = ack_sync & ~ack_prev_q;
      cnt_zero   = (cnt_q == '0);

      if ((state_q != ST_IDLE) && abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  len_d   = read_len;
                  cnt_d   = RST_LOAD;
                  state_d = ST_RESET;
               end
            end
            ST_RESET: begin
               if (cnt_zero) begin
                  cnt_d   = TRIG_LOAD;
                  state_d = ST_TRIGGER;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_TRIGGER: begin
               if (cnt_zero) begin
                  cnt_d   = TIMEOUT_LOAD;
                  state_d = ST_WAIT_ACK;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_WAIT_ACK: begin
               // An acknowledge on the last wait cycle wins over the timeout.
               if (ack_rise) begin
                  if (len_q == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     cnt_d   = len_q - CNT_ONE;
                     state_d = ST_READ;
                  end
               end else if (cnt_zero) begin
                  timeout_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_READ: begin
               if (cnt_zero) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Outputs follow the next state so they change on the same edge as the state.
      chip_rst_d    = (state_d == ST_RESET);
      trig_d        = (state_d == ST_TRIGGER);
      read_clk_en_d = (state_d == ST_READ);
      busy_d        = (state_d != ST_IDLE);
      done_d        = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         len_q         <= '0;
         ack_prev_q    <= 1'b0;
         chip_rst_q    <= 1'b0;
         trig_q        <= 1'b0;
         read_clk_en_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         ack_prev_q    <= ack_prev_d;
         chip_rst_q    <= chip_rst_d;
         trig_q        <= trig_d;
         read_clk_en_q <= read_clk_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
      end
   end

   assign chip_rst     = chip_rst_q;
   assign trig_to_chip = trig_q;
   assign read_clk_en  = read_clk_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: whole sequences are run and the pulse
// lengths, acknowledge latency and completion pulses are tallied and compared.
module tb_readout_sequencer;

   localparam int CW     = 16;
   localparam int BUDGET = 70000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] read_len = '0;
   logic          trig_from_chip = 1'b0;
   logic          chip_rst, trig_to_chip, read_clk_en, busy, done, timeout;

   int checks = 0;
   int errors = 0;
   int n_rst, n_trig, n_rd, n_wait, n_done, n_to, done_c, end_c;

   readout_sequencer #(
      .RST_CYCLES     (16),
      .TRIG_CYCLES    (4),
      .TIMEOUT_CYCLES (4096),
      .CNT_W          (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .read_len       (read_len),
      .trig_from_chip (trig_from_chip),
      .chip_rst       (chip_rst),
      .trig_to_chip   (trig_to_chip),
      .read_clk_en    (read_clk_en),
      .busy           (busy),
      .done           (done),
      .timeout        (timeout)
   );

   initial forever #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // ack_dly: cycles after trig_to_chip falls before a 3-cycle ack (-1 = none).
   // glitch: 1-cycle ack at the start of TRIGGER. restart_at/abort_at: 0 = off.
   task automatic run_seq(input logic [CW-1:0] len, input int ack_dly, input bit glitch,
                          input int restart_at, input int abort_at);
      int   since;
      logic trig_prev;
      n_rst = 0; n_trig = 0; n_rd = 0; n_wait = 0; n_done = 0; n_to = 0;
      done_c = -1; end_c = -1; since = -1; trig_prev = 1'b0;
      read_len = len;
      start = 1'b1;
      tick();
      for (int c = 0; c < BUDGET; c++) begin
         start = 1'b0;
         abort = 1'b0;
         if (!busy) begin
            end_c = c;
            n_to += int'(timeout);
            break;
         end
         n_rst  += int'(chip_rst);
         n_trig += int'(trig_to_chip);
         n_rd   += int'(read_clk_en);
         n_done += int'(done);
         if (done) done_c = c;
         if (!chip_rst && !trig_to_chip && !read_clk_en && !done) n_wait++;
         if (trig_prev && !trig_to_chip) since = 0;
         else if (since >= 0) since++;
         trig_from_chip = (ack_dly >= 0 && since >= ack_dly && since < ack_dly + 3) ||
                          (glitch && trig_to_chip && !trig_prev);
         trig_prev = trig_to_chip;
         if (restart_at > 0 && chip_rst && n_rst == restart_at) begin
            start    = 1'b1;
            read_len = 16'd7;
         end
         if (abort_at > 0 && read_clk_en && n_rd == abort_at) abort = 1'b1;
         tick();
      end
      trig_from_chip = 1'b0;
      check("seq_ended", int'(end_c >= 0), 1);
   endtask

   initial begin
      repeat (3) tick();
      check("reset_outputs", {chip_rst, trig_to_chip, read_clk_en, busy, done, timeout}, 0);
      rst = 1'b0;

      // start in the very first cycle after reset release
      run_seq(16'd10, 20, 1'b0, 0, 0);
      check("n1_chip_rst", n_rst, 16);
      check("n1_trig", n_trig, 4);
      check("n1_wait", n_wait, 23);
      check("n1_read", n_rd, 10);
      check("n1_done", n_done, 1);
      check("n1_idle_gap", end_c - done_c, 1);
      check("n1_timeout", n_to, 0);
      tick();

      run_seq(16'd10, -1, 1'b0, 0, 0);
      check("to_wait", n_wait, 4096);
      check("to_pulse", n_to, 1);
      check("to_read", n_rd, 0);
      check("to_done", n_done, 0);
      tick();
      check("to_single", int'(timeout), 0);

      run_seq(16'd0, 2, 1'b0, 0, 0);
      check("z_read", n_rd, 0);
      check("z_done", n_done, 1);
      check("z_wait", n_wait, 5);
      tick();

      run_seq(16'd10, 1, 1'b0, 0, 3);
      check("ab_read", n_rd, 3);
      check("ab_done", n_done, 0);
      check("ab_timeout", n_to, 0);
      run_seq(16'd10, 1, 1'b0, 0, 0);
      check("ab_next_read", n_rd, 10);
      check("ab_next_done", n_done, 1);
      tick();

      run_seq(16'd10, 5, 1'b1, 5, 0);
      check("ig_chip_rst", n_rst, 16);
      check("ig_trig", n_trig, 4);
      check("ig_wait", n_wait, 8);
      check("ig_read", n_rd, 10);
      check("ig_done", n_done, 1);
      tick();

      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("idle_abort_start", {busy, chip_rst}, 0);

      // asynchronous reset in the middle of RESET
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("mid_rst_high", int'(chip_rst), 1);
      #2 rst = 1'b1;
      #1 check("async_drop", {chip_rst, busy}, 0);
      tick();
      rst = 1'b0;
      tick();
      run_seq(16'd10, 3, 1'b0, 0, 0);
      check("post_rst_chip_rst", n_rst, 16);
      check("post_rst_read", n_rd, 10);
      check("post_rst_done", n_done, 1);
      tick();

      run_seq(16'hFFFF, 0, 1'b0, 0, 0);
      check("max_read", n_rd, 65535);
      check("max_done", n_done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
